// File: rtl/ov_sccb_pkg.sv
// Shared types and constants for the OV-style SCCB slave.
package ov_sccb_pkg;

   localparam int unsigned PHASE_BITS       = 9;
   localparam logic [6:0]  DEFAULT_DEV_ADDR = 7'h21;
   localparam int unsigned CNT_W            = 4;

   typedef enum logic [3:0] {
      S_IDLE,
      S_ID,
      S_ID_ACK,
      S_SUB,
      S_SUB_ACK,
      S_WDATA,
      S_WDATA_ACK,
      S_RDATA,
      S_RDATA_NA,
      S_WAIT_STOP
   } state_t;

endpackage

// File: rtl/ov_sccb_sync.sv
// Synchronizers for SIO_C / SIO_D plus clock-edge and START/STOP detection.
module ov_sccb_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic sio_c,
   input  logic sio_d_in,
   output logic sio_d_s,
   output logic c_rise_c,
   output logic c_fall_c,
   output logic start_c,
   output logic stop_c
);

   logic [SYNC_STAGES-1:0] c_sync;
   logic [SYNC_STAGES-1:0] d_sync;
   logic                   c_prev;
   logic                   d_prev;
   logic                   c_now;

   assign c_now   = c_sync[SYNC_STAGES-1];
   assign sio_d_s = d_sync[SYNC_STAGES-1];

   // Shift chains idle high (bus idle) and remember the previous synchronized level.
   always_ff @(posedge clk) begin
      if (reset) begin
         c_sync <= '1;
         d_sync <= '1;
         c_prev <= 1'b1;
         d_prev <= 1'b1;
      end else begin
         c_sync <= SYNC_STAGES'({c_sync, sio_c});
         d_sync <= SYNC_STAGES'({d_sync, sio_d_in});
         c_prev <= c_now;
         d_prev <= sio_d_s;
      end
   end

   // Edge and bus-condition decode on the synchronized levels.
   always_comb begin
      c_rise_c = c_now & ~c_prev;
      c_fall_c = ~c_now & c_prev;
      start_c  = c_now & c_prev & d_prev & ~sio_d_s;
      stop_c   = c_now & c_prev & ~d_prev & sio_d_s;
   end

endmodule

// File: rtl/ov_sccb_slave.sv
// SCCB (OmniVision) slave: 3-phase write, 2-phase read, burst auto-increment.
module ov_sccb_slave
   import ov_sccb_pkg::*;
#(
   parameter logic [6:0]  DEV_ADDR    = DEFAULT_DEV_ADDR,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sio_c,
   input  logic       sio_d_in,
   output logic       sio_d_oe,
   output logic       sio_d_out,
   input  logic       sccb_e,
   input  logic       pwdn,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_we,
   output logic       reg_rd,
   input  logic [7:0] reg_rdata,
   output logic       busy
);

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PHASE_BITS - 2);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       sr;
   logic             rw;
   logic             ack_on;
   logic [1:0]       rd_phase;
   logic             sio_d_s;
   logic             c_rise_c;
   logic             c_fall_c;
   logic             start_c;
   logic             stop_c;

   ov_sccb_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk      (clk),
      .reset    (reset),
      .sio_c    (sio_c),
      .sio_d_in (sio_d_in),
      .sio_d_s  (sio_d_s),
      .c_rise_c (c_rise_c),
      .c_fall_c (c_fall_c),
      .start_c  (start_c),
      .stop_c   (stop_c)
   );

   // Protocol FSM; bus-level aborts take priority over per-state handling.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         sr        <= 8'h00;
         rw        <= 1'b0;
         ack_on    <= 1'b0;
         rd_phase  <= 2'd0;
         sio_d_oe  <= 1'b0;
         sio_d_out <= 1'b1;
         reg_addr  <= 8'h00;
         reg_wdata <= 8'h00;
         reg_we    <= 1'b0;
         reg_rd    <= 1'b0;
         busy      <= 1'b0;
      end else begin
         reg_we <= 1'b0;
         reg_rd <= 1'b0;
         // Burst writes advance the sub-address once the strobe has been seen.
         if (reg_we) reg_addr <= reg_addr + 8'd1;

         if (sccb_e || pwdn || stop_c) begin
            state     <= S_IDLE;
            sio_d_oe  <= 1'b0;
            sio_d_out <= 1'b1;
            ack_on    <= 1'b0;
            rd_phase  <= 2'd0;
            cnt       <= '0;
            busy      <= 1'b0;
         end else if (start_c) begin
            state     <= S_ID;
            sio_d_oe  <= 1'b0;
            sio_d_out <= 1'b1;
            ack_on    <= 1'b0;
            rd_phase  <= 2'd0;
            cnt       <= '0;
            busy      <= 1'b1;
         end else begin
            case (state)
               S_IDLE: begin
                  sio_d_oe <= 1'b0;
               end
               S_ID: begin
                  if (c_rise_c) begin
                     sr <= {sr[6:0], sio_d_s};
                     if (cnt == LAST_BIT) begin
                        cnt <= '0;
                        rw  <= sio_d_s;
                        // sr[6:0] holds the seven ID bits; sio_d_s is R/W.
                        state <= (sr[6:0] == DEV_ADDR) ? S_ID_ACK : S_WAIT_STOP;
                     end else begin
                        cnt <= cnt + CNT_W'(1);
                     end
                  end
               end
               S_SUB, S_WDATA: begin
                  if (c_rise_c) begin
                     sr <= {sr[6:0], sio_d_s};
                     if (cnt == LAST_BIT) begin
                        cnt <= '0;
                        if (state == S_SUB) begin
                           reg_addr <= {sr[6:0], sio_d_s};
                           state    <= S_SUB_ACK;
                        end else begin
                           reg_wdata <= {sr[6:0], sio_d_s};
                           reg_we    <= 1'b1;
                           state     <= S_WDATA_ACK;
                        end
                     end else begin
                        cnt <= cnt + CNT_W'(1);
                     end
                  end
               end
               S_ID_ACK, S_SUB_ACK, S_WDATA_ACK: begin
                  // First fall starts the ACK low, second fall ends the ACK bit.
                  if (c_fall_c) begin
                     if (!ack_on) begin
                        ack_on    <= 1'b1;
                        sio_d_oe  <= 1'b1;
                        sio_d_out <= 1'b0;
                     end else begin
                        ack_on    <= 1'b0;
                        sio_d_oe  <= 1'b0;
                        sio_d_out <= 1'b1;
                        if (state == S_ID_ACK && rw) begin
                           state    <= S_RDATA;
                           reg_rd   <= 1'b1;
                           rd_phase <= 2'd1;
                        end else if (state == S_ID_ACK) begin
                           state <= S_SUB;
                        end else begin
                           state <= S_WDATA;
                        end
                     end
                  end
               end
               S_RDATA: begin
                  // Wait out the register-file latency before driving bit 7.
                  if (rd_phase == 2'd1) begin
                     rd_phase <= 2'd2;
                  end else if (rd_phase == 2'd2) begin
                     rd_phase  <= 2'd0;
                     sr        <= reg_rdata;
                     sio_d_oe  <= 1'b1;
                     sio_d_out <= reg_rdata[7];
                     cnt       <= '0;
                  end else begin
                     if (c_fall_c) begin
                        sr        <= {sr[6:0], 1'b0};
                        sio_d_out <= sr[6];
                     end
                     if (c_rise_c) begin
                        if (cnt == LAST_BIT) begin
                           cnt   <= '0;
                           state <= S_RDATA_NA;
                        end else begin
                           cnt <= cnt + CNT_W'(1);
                        end
                     end
                  end
               end
               S_RDATA_NA: begin
                  if (c_fall_c) begin
                     sio_d_oe  <= 1'b0;
                     sio_d_out <= 1'b1;
                     reg_addr  <= reg_addr + 8'd1;
                     state     <= S_WAIT_STOP;
                  end
               end
               S_WAIT_STOP: begin
                  sio_d_oe <= 1'b0;
               end
               default: begin
                  state    <= S_IDLE;
                  sio_d_oe <= 1'b0;
                  busy     <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
